trng_conditioner: RTL and testbench

TRNG_CONDITIONER -- requirements
Module: trng_conditioner

---
 rtl/trng_pkg.sv | 19 +
 rtl/trng_fifo.sv | 46 ++++
 rtl/trng_conditioner.sv | 148 ++++++++++++++
 tb/tb_trng_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared constants for the TRNG conditioner: mode encodings, default
// parameter values and the collection state encoding.
package trng_pkg;

  localparam int NCH_DEF       = 4;
  localparam int WORD_W_DEF    = 8;
  localparam int DEPTH_DEF     = 4;
  localparam int REP_LIMIT_DEF = 16;

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_VN  = 1'b1;

  typedef enum logic [1:0] {
    ST_FIRST  = 2'd0,
    ST_SECOND = 2'd1,
    ST_FAIL   = 2'd2
  } col_state_e;

endpackage

// File: rtl/trng_fifo.sv
// Show-ahead word FIFO; a push into a full FIFO is written only when a pop
// frees the head slot on the same edge.
module trng_fifo #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  // Head forced to zero when empty so stale storage never shows on the bus.
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trng_conditioner.sv
// TRNG conditioner: synchronizes ring-oscillator bits, optionally debiases
// them, runs a repetition-count health test and packs words into a FIFO.
//
// state     | meaning
// ST_FIRST  | collecting; next sample is a raw bit or the first of a pair
// ST_SECOND | von Neumann first bit held, waiting for the second
// ST_FAIL   | repetition limit reached; collection frozen until clr_fail
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    ro_bits,
  input  logic              mode,
  input  logic              clr_fail,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              health_fail,
  output logic              overflow
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  col_state_e        state, state_nxt;
  logic [NCH-1:0]    sync1, sync2;
  logic              raw_bit;
  logic              mode_q;
  logic              mode_chg;
  logic              first_bit;
  logic [WORD_W-1:0] coll;
  logic [CNT_W-1:0]  bit_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_next;
  logic              prev_bit;
  logic              sample;
  logic              pair_have;
  logic              acc;
  logic              acc_bit;
  logic              rep_hit;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ro_bits;
      sync2 <= sync1;
    end
  end

  assign raw_bit   = ^(sync2 & ch_en);
  assign mode_chg  = (mode != mode_q);
  assign sample    = en && (state != ST_FAIL);
  // A mode change this cycle makes the current sample a "first".
  assign pair_have = (state == ST_SECOND) && !mode_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FIRST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_fail)                state_nxt = ST_FIRST;
    else if (state == ST_FAIL)   state_nxt = ST_FAIL;
    else if (rep_hit)            state_nxt = ST_FAIL;
    else if (sample)             state_nxt = (mode == MODE_VN && !pair_have) ? ST_SECOND : ST_FIRST;
    else if (mode_chg)           state_nxt = ST_FIRST;
  end

  always_comb begin
    acc     = 1'b0;
    acc_bit = raw_bit;
    if (sample && !clr_fail) begin
      if (mode == MODE_RAW) begin
        acc = 1'b1;
      end else if (pair_have) begin
        acc     = (first_bit != raw_bit);
        acc_bit = first_bit;
      end
    end
    rep_next    = (rep_cnt != '0 && acc_bit == prev_bit) ? rep_cnt + 1'b1 : REP_W'(1);
    rep_hit     = acc && (rep_next == REP_W'(REP_LIMIT));
    push        = acc && !rep_hit && (bit_cnt == CNT_W'(WORD_W - 1));
    health_fail = (state == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_RAW;
      first_bit <= 1'b0;
      coll      <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      prev_bit  <= 1'b0;
    end else begin
      mode_q <= mode;
      if (clr_fail) begin
        bit_cnt <= '0;
        rep_cnt <= '0;
      end else if (sample) begin
        if (mode == MODE_VN && !pair_have) first_bit <= raw_bit;
        if (acc) begin
          prev_bit <= acc_bit;
          rep_cnt  <= rep_next;
          coll     <= {coll[WORD_W-2:0], acc_bit};
          bit_cnt  <= (rep_hit || push) ? '0 : bit_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (push && fifo_full && !pop)  overflow <= 1'b1;
  end

  trng_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({coll[WORD_W-2:0], acc_bit}),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: raw and debiased packing, channel
// masking, health test, FIFO overflow/full-pop and mid-word reset.
module tb_trng_conditioner;
  import trng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] ch_en = 4'b0001;
  logic [3:0] ro_bits = 4'b0000;
  logic       mode = MODE_RAW;
  logic       clr_fail = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       health_fail;
  logic       overflow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  trng_conditioner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ch_en       (ch_en),
    .ro_bits     (ro_bits),
    .mode        (mode),
    .clr_fail    (clr_fail),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .health_fail (health_fail),
    .overflow    (overflow)
  );

  // Lets ro settle through the synchronizer, then enables exactly one sample edge.
  task automatic tick_sample(input logic [3:0] ro, input logic rdy);
    ro_bits = ro;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    out_ready = rdy;
    @(posedge clk);
    #1 en = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    tick_sample({3'b000, b}, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; clr_fail = 1'b0; out_ready = 1'b0; ro_bits = '0;
    ch_en = 4'b0001; mode = MODE_RAW;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL rst_health got=%b exp=0", health_fail); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_raw();
    logic [7:0] pat;
    do_reset();
    pat = 8'b1011_0010;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_early_valid got=%b exp=0", out_valid); end
    send_bit(pat[0]);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL raw_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'hB2) begin bad++; $display("FAIL raw_data got=%h exp=b2", out_data); end
    pop_one();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL raw_pop_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_channels();
    logic [3:0] vec [8];
    vec = '{4'b1111, 4'b0100, 4'b0011, 4'b1000, 4'b0001, 4'b1110, 4'b0111, 4'b1101};
    do_reset();
    ch_en = 4'b1011;
    for (int i = 0; i < 8; i++) tick_sample(vec[i], 1'b0);
    total++; if (out_data !== 8'h98) begin bad++; $display("FAIL chan_xor got=%h exp=98", out_data); end
    pop_one();
    ch_en = 4'b0000;
    for (int i = 0; i < 8; i++) tick_sample(4'b1111, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      bad++; $display("FAIL chan_masked got=%b/%h exp=1/00", out_valid, out_data);
    end
    pop_one();
  endtask

  task automatic test_vn();
    logic [19:0] s;
    logic [15:0] p;
    // pairs 01,10,11,00,10,10,01,01,10,01 -> kept bits 0,1,1,1,0,0,1,0
    s = 20'b01_10_11_00_10_10_01_01_10_01;
    do_reset();
    mode = MODE_VN;
    for (int i = 19; i >= 2; i--) send_bit(s[i]);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vn_early_valid got=%b exp=0", out_valid); end
    send_bit(s[1]);
    send_bit(s[0]);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h72) begin
      bad++; $display("FAIL vn_word got=%b/%h exp=1/72", out_valid, out_data);
    end
    pop_one();
    send_bit(1'b1);
    @(posedge clk); #1 mode = MODE_RAW;
    @(posedge clk); #1 mode = MODE_VN;
    @(posedge clk); #1;
    p = 16'b01_01_01_01_10_10_10_10;
    for (int i = 15; i >= 0; i--) send_bit(p[i]);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
      bad++; $display("FAIL vn_mode_clear got=%b/%h exp=1/0f", out_valid, out_data);
    end
    pop_one();
  endtask

  task automatic test_health();
    do_reset();
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
      bad++; $display("FAIL hl_first_word got=%b/%h exp=1/ff", out_valid, out_data);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL hl_15 got=%b exp=0", health_fail); end
    send_bit(1'b1);
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL hl_16 got=%b exp=1", health_fail); end
    send_bit(1'b0);
    send_bit(1'b1);
    total++; if (out_data !== 8'hFF) begin bad++; $display("FAIL hl_fifo_kept got=%h exp=ff", out_data); end
    @(posedge clk); #1 clr_fail = 1'b1;
    @(posedge clk); #1 clr_fail = 1'b0;
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL hl_clr got=%b exp=0", health_fail); end
    pop_one();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hl_no_push got=%b exp=0", out_valid); end
    send_byte(8'hA5);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      bad++; $display("FAIL hl_resume got=%b/%h exp=1/a5", out_valid, out_data);
    end
    pop_one();
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_w [4];
    logic [7:0] last;
    exp_w = '{8'hB2, 8'hC3, 8'hD4, 8'hE5};
    do_reset();
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    last = 8'hE5;
    for (int i = 7; i >= 1; i--) send_bit(last[i]);
    tick_sample({3'b000, last[0]}, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
        bad++; $display("FAIL fp_word%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_w[i]);
      end
      pop_one();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_w [4];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(exp_w[i]);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ov_four got=%b exp=0", overflow); end
    send_byte(8'h55);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_fifth got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
        bad++; $display("FAIL ov_word%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_w[i]);
      end
      pop_one();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ov_dropped got=%b exp=0", out_valid); end
  endtask

  // Runs straight after test_overflow so the sticky overflow is still set.
  task automatic test_reset_midword();
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    total++; if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rm_pre got=%b/%b exp=1/1", overflow, out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || health_fail !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rm_outputs got=%b/%h/%b/%b exp=0/00/0/0", out_valid, out_data, health_fail, overflow);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h96);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h96) begin
      bad++; $display("FAIL rm_fresh got=%b/%h exp=1/96", out_valid, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_channels();
    test_vn();
    test_health();
    test_full_pop();
    test_overflow();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
